// File: rtl/binary_search_engine.sv
// Binary search over a sorted array in an external synchronous memory.
// Supports exact-match and lower-bound modes, caller sub-ranges and configurable read latency.
module binary_search_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] key,
  input  logic [ADDR_WIDTH-1:0] lo_addr,
  input  logic [ADDR_WIDTH-1:0] hi_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH:0]   result_addr,
  output logic [ADDR_WIDTH:0]   probe_count
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PROBE, S_WAIT, S_CMP, S_FINISH
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] key_q;
  logic                  mode_q;
  logic [ADDR_WIDTH:0]   lo, hi, mid;
  logic [CNT_W-1:0]      wait_cnt;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  data_lt_key, data_eq_key;

  // Sum is formed one bit wider than the bounds so lo+hi never wraps.
  assign mid = (ADDR_WIDTH+1)'(({1'b0, lo} + {1'b0, hi}) >> 1);

  always_comb begin
    if (SIGNED_CMP) data_lt_key = $signed(mem_rdata) < $signed(key_q);
    else            data_lt_key = mem_rdata < key_q;
  end
  assign data_eq_key = (mem_rdata == key_q);

  assign mem_rd   = (state == S_PROBE);
  assign done     = (state == S_FINISH);
  assign busy     = (state == S_CHECK) || (state == S_PROBE) ||
                    (state == S_WAIT)  || (state == S_CMP);
  assign mem_addr = (state == S_PROBE) ? mid[ADDR_WIDTH-1:0] : mem_addr_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_CHECK;
      S_CHECK:  state_n = (lo >= hi) ? S_FINISH : S_PROBE;
      S_PROBE:  state_n = (RD_LATENCY > 1) ? S_WAIT : S_CMP;
      S_WAIT:   if (wait_cnt == CNT_W'(RD_LATENCY - 2)) state_n = S_CMP;
      S_CMP:    state_n = (!mode_q && data_eq_key) ? S_FINISH : S_CHECK;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= '0;
      mode_q      <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      wait_cnt    <= '0;
      mem_addr_q  <= '0;
      found       <= 1'b0;
      result_addr <= '0;
      probe_count <= '0;
    end else begin
      mem_addr_q <= mem_addr;
      case (state)
        S_IDLE: if (start) begin
          key_q       <= key;
          mode_q      <= mode;
          lo          <= {1'b0, lo_addr};
          hi          <= {1'b0, hi_addr} + ONE;
          found       <= 1'b0;
          probe_count <= '0;
        end
        // Range exhausted: lo is the insertion point, written here so it is valid with done.
        S_CHECK: if (lo >= hi) result_addr <= lo;
        S_PROBE: begin
          probe_count <= probe_count + ONE;
          wait_cnt    <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + CNT_W'(1);
        S_CMP: begin
          if (data_lt_key) begin
            lo <= mid + ONE;
          end else begin
            hi <= mid;
            if (data_eq_key) begin
              found <= 1'b1;
              if (!mode_q) result_addr <= mid;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_search_engine.sv
// Bench for binary_search_engine: an unsigned RD_LATENCY=1 instance and a signed RD_LATENCY=3 instance,
// each with its own memory model; expected results go through a scoreboard queue.
module tb_binary_search_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0, mode = 1'b0;
  logic [7:0] key = '0;
  logic [4:0] lo_addr = '0, hi_addr = '0;

  logic [4:0] mem_addr0, mem_addr1;
  logic       mem_rd0, mem_rd1;
  logic [7:0] mem_rdata0, mem_rdata1;
  logic       busy0, busy1, done0, done1, found0, found1;
  logic [5:0] result0, result1, probes0, probes1;

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];

  binary_search_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .RD_LATENCY(1), .SIGNED_CMP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .mode(mode), .key(key),
    .lo_addr(lo_addr), .hi_addr(hi_addr), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
    .mem_rdata(mem_rdata0), .busy(busy0), .done(done0), .found(found0),
    .result_addr(result0), .probe_count(probes0)
  );

  binary_search_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .RD_LATENCY(3), .SIGNED_CMP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode), .key(key),
    .lo_addr(lo_addr), .hi_addr(hi_addr), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .mem_rdata(mem_rdata1), .busy(busy1), .done(done1), .found(found1),
    .result_addr(result1), .probe_count(probes1)
  );

  // Memory models: read data is valid only exactly RD_LATENCY cycles after mem_rd, random otherwise.
  logic [7:0] poison = '0;
  logic [7:0] pipe0 = '0;
  logic       vld0 = 1'b0;
  logic [7:0] pipe1 [3];
  logic [2:0] vld1 = '0;
  int         rd_cnt0 = 0, rd_cnt1 = 0;

  always @(posedge clk) begin
    poison   <= 8'($urandom);
    pipe0    <= mem0[mem_addr0];
    vld0     <= mem_rd0;
    pipe1[0] <= mem1[mem_addr1];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    vld1     <= {vld1[1:0], mem_rd1};
    if (mem_rd0) rd_cnt0 <= rd_cnt0 + 1;
    if (mem_rd1) rd_cnt1 <= rd_cnt1 + 1;
  end

  assign mem_rdata0 = vld0    ? pipe0    : poison;
  assign mem_rdata1 = vld1[2] ? pipe1[2] : poison;

  int         sel = 0;
  logic       busy_s, done_s, found_s;
  logic [5:0] result_s, probes_s;
  assign busy_s   = (sel == 1) ? busy1   : busy0;
  assign done_s   = (sel == 1) ? done1   : done0;
  assign found_s  = (sel == 1) ? found1  : found0;
  assign result_s = (sel == 1) ? result1 : result0;
  assign probes_s = (sel == 1) ? probes1 : probes0;

  typedef struct {
    logic found;
    int   result;
    int   max_p;
    int   lat;
  } exp_t;
  exp_t sb [$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] memv(input int s, input int i);
    return (s == 1) ? mem1[i] : mem0[i];
  endfunction

  function automatic bit less(input int s, input logic [7:0] a, input logic [7:0] b);
    if (s == 1) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Linear-scan reference: first index in [lo..hi] whose element is not below key.
  function automatic void ref_search(input int s, input int k, input int lo, input int hi,
                                     output logic f, output int r);
    int i;
    i = lo;
    while (i <= hi && less(s, memv(s, i), 8'(k))) i++;
    r = i;
    f = (i <= hi) && (memv(s, i) == 8'(k));
  endfunction

  // One search; lat = edges from the start-sampling edge to done (-1 skips), restart_at re-pulses start.
  task automatic do_search(input int s, input logic m, input int k, input int lo, input int hi,
                           input logic ef, input int er, input int lat, input int restart_at,
                           input string name);
    exp_t e, got;
    int   cyc, base, seen, n;
    n       = (hi >= lo) ? hi - lo + 1 : 0;
    e.found = ef;
    e.result = er;
    e.max_p = $clog2(n + 1);
    e.lat   = lat;
    @(negedge clk);
    sel = s; mode = m; key = 8'(k); lo_addr = 5'(lo); hi_addr = 5'(hi);
    base = (s == 1) ? rd_cnt1 : rd_cnt0;
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1;
    n_vec++;
    if (busy_s !== 1'b1) begin
      n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_s);
    end
    while (done_s !== 1'b1 && cyc < 300) begin
      if (cyc == restart_at) begin
        key = ~8'(k); mode = ~m; lo_addr = '0; hi_addr = '0;
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      cyc++;
    end
    n_vec++;
    if (done_s !== 1'b1) begin
      n_err++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
      sb.delete();
    end else begin
      got  = sb.pop_front();
      seen = ((s == 1) ? rd_cnt1 : rd_cnt0) - base;
      n_vec++;
      if (found_s !== got.found) begin
        n_err++; $display("FAIL %s found: got %b want %b", name, found_s, got.found);
      end
      n_vec++;
      if (result_s !== 6'(got.result)) begin
        n_err++; $display("FAIL %s result_addr: got %0d want %0d", name, result_s, got.result);
      end
      n_vec++;
      if (probes_s !== 6'(seen)) begin
        n_err++; $display("FAIL %s probe_count: got %0d want %0d reads seen", name, probes_s, seen);
      end
      n_vec++;
      if (seen > got.max_p) begin
        n_err++; $display("FAIL %s probe_bound: got %0d reads want <= %0d", name, seen, got.max_p);
      end
      if (got.lat >= 0) begin
        n_vec++;
        if (cyc != got.lat) begin
          n_err++; $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, got.lat);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy0, done0, found0, mem_rd0} !== 4'b0 || mem_addr0 !== 5'd0 ||
        result0 !== 6'd0 || probes0 !== 6'd0) begin
      n_err++;
      $display("FAIL reset_dut0: got busy=%b done=%b found=%b rd=%b addr=%0d res=%0d probes=%0d want all 0",
               busy0, done0, found0, mem_rd0, mem_addr0, result0, probes0);
    end
    n_vec++;
    if ({busy1, done1, found1, mem_rd1} !== 4'b0 || mem_addr1 !== 5'd0 ||
        result1 !== 6'd0 || probes1 !== 6'd0) begin
      n_err++;
      $display("FAIL reset_dut1: got busy=%b done=%b found=%b rd=%b addr=%0d res=%0d probes=%0d want all 0",
               busy1, done1, found1, mem_rd1, mem_addr1, result1, probes1);
    end
  endtask

  // Per probe L+2 cycles: a hit takes (L+2)*p+1 cycles to done, a miss (L+2)*p+2.
  task automatic test_exact_hit();
    do_search(0, 1'b0, 20, 0, 31, 1'b1, 10, 13, -1, "exact_hit_20");
  endtask

  task automatic test_exact_miss();
    do_search(0, 1'b0, 21,  0, 31, 1'b0, 11, -1, -1, "exact_miss_21");
    do_search(0, 1'b0, 255, 0, 31, 1'b0, 32, 17, -1, "exact_miss_255");
  endtask

  // Empty range: start cycle, CHECK, then done in FINISH -- the third cycle counting the start cycle.
  task automatic test_sub_range();
    do_search(0, 1'b0, 2,  12, 15, 1'b0, 12, -1, -1, "subrange_12_15");
    do_search(0, 1'b0, 14, 7,  7,  1'b1, 7,  -1, -1, "single_entry_7");
    do_search(0, 1'b0, 20, 9,  4,  1'b0, 9,  2,  -1, "empty_9_4");
  endtask

  task automatic test_signed_latency();
    do_search(1, 1'b0, 8'hFB, 0, 31, 1'b1, 11, 26, -1, "signed_m5");
    do_search(1, 1'b1, 8'h80, 0, 31, 1'b0, 0,  -1, -1, "signed_lb_m128");
    do_search(1, 1'b0, 8'h7F, 0, 31, 1'b0, 32, -1, -1, "signed_miss_127");
  endtask

  task automatic test_start_while_busy();
    int extra;
    do_search(0, 1'b0, 20, 0, 31, 1'b1, 10, 13, 3, "start_while_busy");
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0 === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL start_while_busy extra_done: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc, pulses;
    @(negedge clk);
    sel = 1; mode = 1'b0; key = 8'hFB; lo_addr = 5'd0; hi_addr = 5'd31;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (mem_rd1 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    n_vec++;
    if (busy1 !== 1'b1 || mem_rd1 !== 1'b0) begin
      n_err++; $display("FAIL mid_wait_state: got busy=%b rd=%b want busy=1 rd=0", busy1, mem_rd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({busy1, done1, found1, mem_rd1} !== 4'b0 || probes1 !== 6'd0 || result1 !== 6'd0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got busy=%b done=%b found=%b rd=%b probes=%0d res=%0d want all 0",
               busy1, done1, found1, mem_rd1, probes1, result1);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL reset_mid_wait no_done: got %0d pulses want 0", pulses);
    end
    do_search(1, 1'b0, 8'hFB, 0, 31, 1'b1, 11, 26, -1, "post_reset_search");
  endtask

  task automatic test_back_to_back(input int s, input int iters, input string name);
    logic f;
    int   r, lo, hi, k;
    logic m;
    for (int i = 0; i < iters; i++) begin
      lo = $urandom_range(0, 31);
      hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(lo, 31);
      k  = (s == 1) ? $urandom_range(0, 255) : $urandom_range(0, 66);
      m  = 1'($urandom_range(0, 1));
      ref_search(s, k, lo, hi, f, r);
      do_search(s, m, k, lo, hi, f, r, -1, -1, name);
    end
  endtask

  task automatic test_lower_bound_dups();
    mem0[0] = 8'd1;
    for (int i = 1; i < 5; i++)  mem0[i] = 8'd3;
    for (int i = 5; i < 32; i++) mem0[i] = 8'(2 * i - 3);
    do_search(0, 1'b1, 3, 0, 31, 1'b1, 1, -1, -1, "lb_dups_3");
    do_search(0, 1'b1, 2, 0, 31, 1'b0, 1, -1, -1, "lb_dups_2");
    for (int i = 0; i < 8; i++) begin
      logic f;
      int   r, k;
      k = $urandom_range(0, 62);
      ref_search(0, k, 0, 31, f, r);
      do_search(0, 1'b1, k, 0, 31, f, r, -1, -1, "lb_dups_random");
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 8'(2 * i);
      mem1[i] = 8'(i - 16);
    end
    test_reset();
    test_exact_hit();
    test_exact_miss();
    test_sub_range();
    test_signed_latency();
    test_start_while_busy();
    test_reset_mid_wait();
    test_back_to_back(0, 20, "sweep_unsigned");
    test_back_to_back(1, 10, "sweep_signed");
    test_lower_bound_dups();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
